mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and MEM_WB.
- Turns MemRead/MemWrite into a request/ready data-memory bus transaction, generates byte enables, aligns and extends load data, and stalls the pipeline while a transaction is outstanding.
- Produces MemReadData plus the pass-through control and register fields that MEM_WB latches.

Parameters:
- WAIT_MAX, 15: maximum cycles in REQ before abort; 4-bit wait counter, range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  EX/MEM holds a live instruction
- ALUResult_in  in  32  effective address / ALU result
- StoreData_in  in  32  rs2 value for stores
- MemRead_in  in  1  load
- MemWrite_in  in  1  store
- funct3_in  in  3  access size and sign
- MemtoReg_in  in  1  pass-through
- RegWrite_in  in  1  pass-through
- rs1_in, rs2_in, rd_in  in  5 each  pass-through
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, bits[1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- MemReadData_out  out  32  aligned, extended load data
- ALUResult_out  out  32  pass-through
- MemtoReg_out, RegWrite_out  out  1 each  pass-through; RegWrite forced 0 on error
- rs1_out, rs2_out, rd_out  out  5 each  pass-through
- stall_out  out  1  hold IF/ID/EX and EX/MEM; insert bubble into MEM_WB
- bus_err  out  1  one-cycle pulse on timeout abort
- misalign_exc  out  1  one-cycle pulse on misaligned access

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Memory op = valid_in & (MemRead_in | MemWrite_in).
- IDLE:
  - No memory op: all fields pass through combinationally, stall_out = 0.
  - Memory op: stall_out = 1, go to REQ, register address, we, be and wdata.
- REQ:
  - mem_req = 1, bus fields held stable, stall_out = 1, wait counter increments.
  - mem_ready = 1: capture mem_rdata (loads only), go to DONE.
  - Counter reaches WAIT_MAX with mem_ready still 0: go to DONE with an error flag.
- DONE:
  - stall_out = 0; outputs present the completed op; MEM_WB captures at the end of this cycle.
  - bus_err pulses if the error flag is set; RegWrite_out is forced 0 on error.
  - Next state is IDLE.
- Latency: zero-wait memory gives 3 cycles from op presented to MEM_WB capture, i.e. 2 stall cycles. Each wait state adds 1.
- Byte enables, lane = addr[1:0]:
  - funct3 000 (byte): be = 0001 << lane.
  - funct3 001 (half): be = 0011 << (2 * addr[1]).
  - funct3 010 (word): be = 1111.
  - funct3 100 / 101: byte / half, zero-extended.
  - funct3 011, 110, 111: treated as word.
- mem_wdata: byte replicated x4, half replicated x2, word unchanged.
- Loads: select lane, sign-extend (000, 001) or zero-extend (100, 101). Stores: MemReadData_out = 0.
- Misaligned access, macro absent:
  - Half: address bit 0 ignored. Word: bits[1:0] ignored.
  - The access proceeds on the aligned address.
- mem_ready outside REQ is ignored.
- rd = 0 loads still access memory.
- Reset in any state:
  - Next cycle state = IDLE; mem_req, bus_err, misalign_exc, stall_out = 0; counter and captured data cleared.
  - An outstanding request is abandoned.
- Reset values of the other outputs:
  - Registered outputs (mem_we, mem_addr, mem_wdata, mem_be) = 0.
  - Pass-through fields, including RegWrite_out and MemtoReg_out, follow their inputs combinationally; MEM_WB's own reset qualifies them.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned half or word access goes from IDLE straight to DONE with no bus request (1 stall cycle).
  - misalign_exc pulses in DONE and RegWrite_out is forced 0.
- Undefined: misalign_exc is tied 0 and misaligned accesses align as described under Behaviour.

Decomposition:
- Shared package riscv_mem_pkg: funct3 size/sign constants, FSM state typedef, default WAIT_MAX.
- Sub-module load_align: combinational lane select and sign/zero extension, also reusable by a future cache.

Test Plan:
- LW addr 0x100, mem_ready high on the first REQ cycle, rdata 0xDEADBEEF -> stall_out high for 2 cycles; MemReadData_out 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF_FFFF -> be 1000, MemReadData_out 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x202, data 0x1234ABCD, 3 wait states -> mem_we 1, be 1100, wdata 0xABCDABCD held stable for 4 REQ cycles, stall_out held throughout.
- mem_ready never asserted, WAIT_MAX 15 -> abort after 15 REQ cycles; bus_err pulses once; RegWrite_out 0; stall_out drops.
- Reset asserted during the second REQ cycle -> mem_req 0 and state IDLE next cycle; a later ALU-only op passes through with stall_out 0.
- LW addr 0x101 -> with MEM_STAGE_MISALIGN_TRAP_EN: no mem_req, misalign_exc pulses, RegWrite_out 0. Without the macro: mem_addr 0x100, be 1111.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: funct3 size/sign
// encodings, the LSU FSM state type, the default bus timeout and lane helpers.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    localparam int WAIT_MAX_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // funct3[1:0] carries the size; every encoding other than byte/half is a word
    function automatic logic [3:0] byteEnable(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            SIZE_BYTE: byteEnable = 4'b0001 << lane;
            SIZE_HALF: byteEnable = lane[1] ? 4'b1100 : 4'b0011;
            default:   byteEnable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeLanes(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            SIZE_BYTE: storeLanes = {4{data[7:0]}};
            SIZE_HALF: storeLanes = {2{data[15:0]}};
            default:   storeLanes = data;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            SIZE_BYTE: isMisaligned = 1'b0;
            SIZE_HALF: isMisaligned = lane[0];
            default:   isMisaligned = |lane;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select with sign/zero extension; half accesses use
// only lane[1] and word accesses ignore the lane entirely.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = 8'h00;
        case (lane_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
        halfSel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            F3_LBU:  data_o = {24'h000000, byteSel};
            F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            F3_LHU:  data_o = {16'h0000, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/ready bus sequencing, byte enables, load
// alignment and pipeline stall. Optional trap on misaligned access: MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] StoreData_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] MemReadData_out,
    output logic [31:0] ALUResult_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic        stall_out,
    output logic        bus_err,
    output logic        misalign_exc
);

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

    lsu_state_t  state_q;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        we_q, req_q, isLoad_q, busErr_q;
    logic        memOp;
    logic [31:0] alignedData;

    assign memOp     = valid_in & (MemRead_in | MemWrite_in);
    assign waitCnt_d = waitCnt_q + 4'd1;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalExc_q;
    assign misaligned   = isMisaligned(funct3_in, ALUResult_in[1:0]);
    assign misalign_exc = misalExc_q;
`else
    assign misalign_exc = 1'b0;
`endif

    // waitCnt_q holds the 1-based index of the current REQ cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            be_q      <= 4'h0;
            lane_q    <= 2'd0;
            funct3_q  <= 3'd0;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            isLoad_q  <= 1'b0;
            busErr_q  <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalExc_q <= 1'b0;
`endif
        end else begin
            busErr_q <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalExc_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (memOp) begin
                        addr_q    <= {ALUResult_in[31:2], 2'b00};
                        we_q      <= MemWrite_in;
                        be_q      <= byteEnable(funct3_in, ALUResult_in[1:0]);
                        wdata_q   <= storeLanes(funct3_in, StoreData_in);
                        lane_q    <= ALUResult_in[1:0];
                        funct3_q  <= funct3_in;
                        isLoad_q  <= MemRead_in;
                        rdata_q   <= 32'h0;
                        waitCnt_q <= 4'd1;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state_q    <= DONE;
                            misalExc_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        if (isLoad_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else if (waitCnt_q == WAIT_LIMIT) begin
                        req_q    <= 1'b0;
                        state_q  <= DONE;
                        busErr_q <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i  (rdata_q),
        .lane_i   (lane_q),
        .funct3_i (funct3_q),
        .data_o   (alignedData)
    );

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign bus_err   = busErr_q;

    // EX/MEM is frozen while stalled, so the pass-through fields stay valid until DONE
    assign stall_out       = ((state_q == IDLE) & memOp) | (state_q == REQ);
    assign MemReadData_out = ((state_q == DONE) & isLoad_q) ? alignedData : 32'h0;
    assign RegWrite_out    = RegWrite_in & ~(busErr_q | misalign_exc);
    assign ALUResult_out   = ALUResult_in;
    assign MemtoReg_out    = MemtoReg_in;
    assign rs1_out         = rs1_in;
    assign rs2_out         = rs2_in;
    assign rd_out          = rd_in;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; misalignment expectations
// follow MEM_STAGE_MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] ALUResult_in, StoreData_in, mem_rdata;
    logic        MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, mem_ready;
    logic [2:0]  funct3_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic        mem_req, mem_we, MemtoReg_out, RegWrite_out, stall_out, bus_err, misalign_exc;
    logic [31:0] mem_addr, mem_wdata, MemReadData_out, ALUResult_out;
    logic [3:0]  mem_be;
    logic [4:0]  rs1_out, rs2_out, rd_out;

    int checkCount = 0;
    int failCount  = 0;

    int          stallCnt, reqCnt, errPulses, misalPulses;
    logic        gotDone, stable, weSeen, doneRegWrite;
    logic [31:0] doneData, addrSeen, wdataSeen;
    logic [3:0]  beSeen;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .ALUResult_in(ALUResult_in), .StoreData_in(StoreData_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .funct3_in(funct3_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .MemReadData_out(MemReadData_out), .ALUResult_out(ALUResult_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .stall_out(stall_out), .bus_err(bus_err), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rdEn, input logic wrEn, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] sdata, input logic regW);
        valid_in     = v;
        MemRead_in   = rdEn;
        MemWrite_in  = wrEn;
        funct3_in    = f3;
        ALUResult_in = alu;
        StoreData_in = sdata;
        RegWrite_in  = regW;
        MemtoReg_in  = rdEn;
    endtask

    // Drives one memory op and plays the memory side; waits < 0 means never ready
    task automatic runMemOp(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input int waits, input logic [31:0] rdata);
        logic stalled;
        applyStimulus(1'b1, isLoad, ~isLoad, f3, addr, sdata, isLoad);
        stallCnt = 0; reqCnt = 0; errPulses = 0; misalPulses = 0;
        gotDone = 1'b0; stable = 1'b1; stalled = 1'b0;
        doneData = 32'h0; doneRegWrite = 1'b0;
        addrSeen = 32'h0; wdataSeen = 32'h0; beSeen = 4'h0; weSeen = 1'b0;
        for (int cyc = 0; cyc < 40 && !gotDone; cyc++) begin
            @(negedge clk);
            if (bus_err) errPulses++;
            if (misalign_exc) misalPulses++;
            if (mem_req) begin
                reqCnt++;
                if (reqCnt == 1) begin
                    addrSeen = mem_addr; wdataSeen = mem_wdata; beSeen = mem_be; weSeen = mem_we;
                end else if (mem_addr !== addrSeen || mem_wdata !== wdataSeen ||
                             mem_be !== beSeen || mem_we !== weSeen) begin
                    stable = 1'b0;
                end
                mem_ready = (waits >= 0) && (reqCnt == waits + 1);
                mem_rdata = mem_ready ? rdata : 32'h0BAD_0BAD;
            end else begin
                mem_ready = 1'b0;
            end
            if (stall_out) begin
                stallCnt++;
                stalled = 1'b1;
            end else if (stalled) begin
                gotDone      = 1'b1;
                doneData     = MemReadData_out;
                doneRegWrite = RegWrite_out;
            end
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        if (!gotDone) checkOutput("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        rs1_in = 5'd1; rs2_in = 5'd2; rd_in = 5'd9;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req",   {31'h0, mem_req}, 32'd0);
        checkOutput("rst_we",    {31'h0, mem_we}, 32'd0);
        checkOutput("rst_addr",  mem_addr, 32'h0);
        checkOutput("rst_be",    {28'h0, mem_be}, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        checkOutput("rst_stall", {31'h0, stall_out}, 32'd0);
        checkOutput("rst_err",   {31'h0, bus_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        runMemOp(1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        checkOutput("lw_stall", stallCnt, 32'd2);
        checkOutput("lw_req",   reqCnt, 32'd1);
        checkOutput("lw_addr",  addrSeen, 32'h100);
        checkOutput("lw_be",    {28'h0, beSeen}, 32'hF);
        checkOutput("lw_we",    {31'h0, weSeen}, 32'd0);
        checkOutput("lw_data",  doneData, 32'hDEAD_BEEF);
        checkOutput("lw_rw",    {31'h0, doneRegWrite}, 32'd1);

        runMemOp(1'b1, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        checkOutput("lb_be",   {28'h0, beSeen}, 32'h8);
        checkOutput("lb_addr", addrSeen, 32'h100);
        checkOutput("lb_data", doneData, 32'hFFFF_FF80);
        runMemOp(1'b1, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        checkOutput("lbu_data", doneData, 32'h0000_0080);

        runMemOp(1'b1, 3'b001, 32'h102, 32'h0, 1, 32'h8001_0000);
        checkOutput("lh_be",    {28'h0, beSeen}, 32'hC);
        checkOutput("lh_data",  doneData, 32'hFFFF_8001);
        checkOutput("lh_stall", stallCnt, 32'd3);
        runMemOp(1'b1, 3'b101, 32'h102, 32'h0, 0, 32'h8001_0000);
        checkOutput("lhu_data", doneData, 32'h0000_8001);

        runMemOp(1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'h0);
        checkOutput("sh_we",     {31'h0, weSeen}, 32'd1);
        checkOutput("sh_be",     {28'h0, beSeen}, 32'hC);
        checkOutput("sh_wdata",  wdataSeen, 32'hABCD_ABCD);
        checkOutput("sh_addr",   addrSeen, 32'h200);
        checkOutput("sh_req",    reqCnt, 32'd4);
        checkOutput("sh_stable", {31'h0, stable}, 32'd1);
        checkOutput("sh_stall",  stallCnt, 32'd5);
        checkOutput("sh_rdata",  doneData, 32'h0);

        runMemOp(1'b0, 3'b000, 32'h101, 32'h0000_00EF, 0, 32'h0);
        checkOutput("sb_be",    {28'h0, beSeen}, 32'h2);
        checkOutput("sb_wdata", wdataSeen, 32'hEFEF_EFEF);

        runMemOp(1'b1, 3'b010, 32'h400, 32'h0, -1, 32'h0);
        checkOutput("to_req",    reqCnt, 32'd15);
        checkOutput("to_stall",  stallCnt, 32'd16);
        checkOutput("to_err",    errPulses, 32'd1);
        checkOutput("to_rw",     {31'h0, doneRegWrite}, 32'd0);
        checkOutput("to_data",   doneData, 32'h0);
        @(negedge clk);
        checkOutput("to_errclr", {31'h0, bus_err}, 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rr_req_pre", {31'h0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rr_req",   {31'h0, mem_req}, 32'd0);
        checkOutput("rr_stall", {31'h0, stall_out}, 32'd0);
        checkOutput("rr_addr",  mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rd_in = 5'd7;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0055, 32'h0, 1'b1);
        #1;
        checkOutput("alu_stall", {31'h0, stall_out}, 32'd0);
        checkOutput("alu_res",   ALUResult_out, 32'h55);
        checkOutput("alu_rd",    {27'h0, rd_out}, 32'd7);
        checkOutput("alu_rw",    {31'h0, RegWrite_out}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("alu_noreq", {31'h0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        rd_in = 5'd9;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

        runMemOp(1'b1, 3'b010, 32'h101, 32'h0, 0, 32'hCAFE_F00D);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        checkOutput("ma_req",   reqCnt, 32'd0);
        checkOutput("ma_exc",   misalPulses, 32'd1);
        checkOutput("ma_rw",    {31'h0, doneRegWrite}, 32'd0);
        checkOutput("ma_stall", stallCnt, 32'd1);
`else
        checkOutput("ma_addr", addrSeen, 32'h100);
        checkOutput("ma_be",   {28'h0, beSeen}, 32'hF);
        checkOutput("ma_exc",  misalPulses, 32'd0);
        checkOutput("ma_data", doneData, 32'hCAFE_F00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
